sc_screen_sequencer: RTL and testbench
======================================

# sc_screen_sequencer

Game-flow controller for the RoadFighter display path. It owns the select input of the 4:1 screen-pattern multiplexer and sequences it through boot, attract (wait for start), pattern load, play and crash-blink phases. It is paced by a one-cycle tick from the existing prescaler. It also issues the road-shift enable and pattern-load strobe to the datapath registers.

## Interface
- SELWIDTH, 2: width of the mux select output.
- CNTWIDTH, 4: width of the internal tick counter.
- BOOT_TICKS, 4: ticks spent in BOOT before entering IDLE (1..2^CNTWIDTH-1).
- LOSE_TICKS, 8: ticks spent in CRASH before returning to IDLE (1..2^CNTWIDTH-1).

Ports:
- SC_SCREENSEQ_CLOCK_50  in  1  system clock; all state changes on its rising edge.
- SC_SCREENSEQ_RESET_InHigh  in  1  asynchronous, active-high reset.
- SC_SCREENSEQ_TICK_In  in  1  one-clock pulse from the prescaler; the only timebase.
- SC_SCREENSEQ_START_InLow  in  1  start button, active low, already synchronized and debounced upstream.
- SC_SCREENSEQ_CRASH_InHigh  in  1  collision flag from the datapath comparator.
- SC_SCREENSEQ_SELECT_Out  out  SELWIDTH  mux select: 0=all zeros, 1=all ones, 2=random load, 3=game screen.
- SC_SCREENSEQ_LOAD_Out  out  1  one-cycle strobe that loads the random/initial road pattern.
- SC_SCREENSEQ_SHIFT_Out  out  1  road-shift enable.
- SC_SCREENSEQ_STATE_Out  out  3  current state code, for debug/LEDs.

## Operation
- States and codes: BOOT=0, IDLE=1, LOAD=2, PLAY=3, CRASH=4. Codes 5–7 are illegal and go to BOOT on the next clock.
- Reset values: state BOOT, counter 0, SELECT 0, LOAD 0, STATE 0, blink phase 0, start-history register 1 (released).
- BOOT: SELECT=0. The counter increments on each tick. On the tick that brings the counter to BOOT_TICKS, go to IDLE and clear the counter.
- IDLE: SELECT=1.
  - The start event is a falling edge of START_InLow: previous sample 1, current sample 0.
  - On a start event, go to LOAD.
  - A button held low from reset onward is not a start event. Release and press again to start.
- LOAD: SELECT=2 and LOAD=1, for exactly one clock. Then go unconditionally to PLAY.
- PLAY: SELECT=3.
  - If CRASH_InHigh=1, go to CRASH and clear the counter.
  - Crash takes priority over a simultaneous tick.
- CRASH: SELECT alternates between 0 and 3.
  - On entry SELECT=0 (blink phase 0). The phase toggles on every tick.
  - The counter increments on each tick. On the tick that brings the counter to LOSE_TICKS, go to IDLE.
  - Counter and phase clear when CRASH is left.
- Inputs outside their states are ignored:
  - CRASH_InHigh outside PLAY.
  - START_InLow outside IDLE; a press during CRASH or BOOT does not queue a start.
  - The start-history register samples every clock in every state.
- Counter arithmetic: unsigned CNTWIDTH bits, compared for equality to the parameter. It never wraps because it clears on every exit.

## Timing
- SELECT, LOAD and STATE are registered (Moore outputs). They change on the same clock edge as the state register and are valid for the whole first cycle of the new state.
- SHIFT_Out is combinational: TICK_In AND (state==PLAY) AND NOT CRASH_InHigh. Same-cycle as the tick, and never asserted on the cycle a crash is taken.
- Start latency: a falling edge sampled at clock edge N gives LOAD=1 in cycle N+1 and SELECT=3 in cycle N+2.
- Crash latency: CRASH_InHigh sampled high at edge N gives SELECT=0 and STATE=4 in cycle N+1.
- Reset asserted in any state forces all registered outputs to their reset values immediately (asynchronous assert). Release is synchronous to the next clock edge. SHIFT drops immediately because state is BOOT.

## Test plan
- Reset then boot, BOOT_TICKS=4, tick every 10 clocks -> SELECT=0 until the 4th tick, SELECT=1 and STATE=1 on the following clock; LOAD and SHIFT stay 0 throughout.
- Start press in IDLE (START_InLow 1→0, held for 20 clocks) -> exactly one LOAD=1 cycle with SELECT=2, then SELECT=3, STATE=3. A second press while in PLAY has no effect.
- START_InLow held low through reset and boot -> stays in IDLE; release then press -> LOAD pulse one clock after the press is sampled.
- In PLAY, 3 ticks, then CRASH_InHigh=1 coincident with the 4th tick -> SHIFT pulses 3 times, not on the 4th. Next cycle SELECT=0, STATE=4. With LOSE_TICKS=8, SELECT toggles 0/3 on each tick and returns to 1 (IDLE) on the clock after the 8th tick.
- Reset asserted mid-PLAY and mid-CRASH, asynchronous to the clock -> SELECT=0, STATE=0, LOAD=0, SHIFT=0 before the next clock edge. A full BOOT sequence follows release.
- Force the state register to 6 (illegal code) -> STATE=0 and SELECT=0 on the next clock.

Source files
------------

// File: rtl/sc_screen_sequencer.sv
// Game-flow controller for the RoadFighter display path: drives the screen-pattern
// mux select through boot, attract, pattern load, play and crash-blink phases.
module sc_screen_sequencer #(
    parameter int SELWIDTH   = 2,
    parameter int CNTWIDTH   = 4,
    parameter int BOOT_TICKS = 4,
    parameter int LOSE_TICKS = 8
) (
    input  logic                SC_SCREENSEQ_CLOCK_50,
    input  logic                SC_SCREENSEQ_RESET_InHigh,
    input  logic                SC_SCREENSEQ_TICK_In,
    input  logic                SC_SCREENSEQ_START_InLow,
    input  logic                SC_SCREENSEQ_CRASH_InHigh,
    output logic [SELWIDTH-1:0] SC_SCREENSEQ_SELECT_Out,
    output logic                SC_SCREENSEQ_LOAD_Out,
    output logic                SC_SCREENSEQ_SHIFT_Out,
    output logic [2:0]          SC_SCREENSEQ_STATE_Out
);

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_PLAY  = 3'd3,
        ST_CRASH = 3'd4
    } state_t;

    localparam logic [CNTWIDTH-1:0] BOOT_CNT = CNTWIDTH'(BOOT_TICKS);
    localparam logic [CNTWIDTH-1:0] LOSE_CNT = CNTWIDTH'(LOSE_TICKS);
    localparam logic [SELWIDTH-1:0] SEL_ZERO = SELWIDTH'(0);
    localparam logic [SELWIDTH-1:0] SEL_ONES = SELWIDTH'(1);
    localparam logic [SELWIDTH-1:0] SEL_RAND = SELWIDTH'(2);
    localparam logic [SELWIDTH-1:0] SEL_GAME = SELWIDTH'(3);

    // Plain vector rather than state_t so that any 3-bit code, legal or not, can be held.
    logic [2:0]          state_reg, state_next;
    logic [CNTWIDTH-1:0] cnt_reg, cnt_next, cnt_inc;
    logic                phase_reg, phase_next;
    logic                start_hist_reg;
    logic [SELWIDTH-1:0] select_reg, select_next;
    logic                load_reg, load_next;
    logic                start_event;

    assign cnt_inc     = cnt_reg + CNTWIDTH'(1);
    assign start_event = start_hist_reg & ~SC_SCREENSEQ_START_InLow;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        phase_next = phase_reg;
        case (state_reg)
            ST_BOOT: begin
                if (SC_SCREENSEQ_TICK_In) begin
                    if (cnt_inc == BOOT_CNT) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
            end
            ST_IDLE: begin
                if (start_event) state_next = ST_LOAD;
            end
            ST_LOAD: state_next = ST_PLAY;
            ST_PLAY: begin
                if (SC_SCREENSEQ_CRASH_InHigh) begin
                    state_next = ST_CRASH;
                    cnt_next   = '0;
                    phase_next = 1'b0;
                end
            end
            ST_CRASH: begin
                if (SC_SCREENSEQ_TICK_In) begin
                    if (cnt_inc == LOSE_CNT) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                        phase_next = 1'b0;
                    end else begin
                        cnt_next   = cnt_inc;
                        phase_next = ~phase_reg;
                    end
                end
            end
            default: begin
                state_next = ST_BOOT;
                cnt_next   = '0;
                phase_next = 1'b0;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        select_next = SEL_ZERO;
        case (state_next)
            ST_IDLE:  select_next = SEL_ONES;
            ST_LOAD:  select_next = SEL_RAND;
            ST_PLAY:  select_next = SEL_GAME;
            ST_CRASH: select_next = phase_next ? SEL_GAME : SEL_ZERO;
            default:  select_next = SEL_ZERO;
        endcase
        load_next = (state_next == ST_LOAD);
    end

    always_ff @(posedge SC_SCREENSEQ_CLOCK_50 or posedge SC_SCREENSEQ_RESET_InHigh) begin
        if (SC_SCREENSEQ_RESET_InHigh) begin
            state_reg      <= ST_BOOT;
            cnt_reg        <= '0;
            phase_reg      <= 1'b0;
            start_hist_reg <= 1'b1;
            select_reg     <= SEL_ZERO;
            load_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            phase_reg      <= phase_next;
            start_hist_reg <= SC_SCREENSEQ_START_InLow;
            select_reg     <= select_next;
            load_reg       <= load_next;
        end
    end

    assign SC_SCREENSEQ_SELECT_Out = select_reg;
    assign SC_SCREENSEQ_LOAD_Out   = load_reg;
    assign SC_SCREENSEQ_STATE_Out  = state_reg;
    assign SC_SCREENSEQ_SHIFT_Out  = SC_SCREENSEQ_TICK_In && (state_reg == ST_PLAY)
                                     && !SC_SCREENSEQ_CRASH_InHigh;

endmodule

// File: tb/tb_sc_screen_sequencer.sv
// Directed self-checking bench for sc_screen_sequencer: boot, start, play, crash blink,
// held-start rejection, asynchronous reset and illegal-state recovery.
module tb_sc_screen_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       start_n;
    logic       crash;
    logic [1:0] sel;
    logic       load;
    logic       shift;
    logic [2:0] state;

    int n_check = 0;
    int n_pass  = 0;
    int shift_seen;

    sc_screen_sequencer #(
        .SELWIDTH(2), .CNTWIDTH(4), .BOOT_TICKS(4), .LOSE_TICKS(8)
    ) dut (
        .SC_SCREENSEQ_CLOCK_50    (clk),
        .SC_SCREENSEQ_RESET_InHigh(rst),
        .SC_SCREENSEQ_TICK_In     (tick),
        .SC_SCREENSEQ_START_InLow (start_n),
        .SC_SCREENSEQ_CRASH_InHigh(crash),
        .SC_SCREENSEQ_SELECT_Out  (sel),
        .SC_SCREENSEQ_LOAD_Out    (load),
        .SC_SCREENSEQ_SHIFT_Out   (shift),
        .SC_SCREENSEQ_STATE_Out   (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_check++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle tick; SHIFT is captured while the tick is up, before the edge consumes it.
    task automatic pulse_tick();
        tick = 1'b1;
        #1 shift_seen = int'(shift);
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic outs(input string tag, input int exp_sel, input int exp_state,
                        input int exp_load);
        $display("%0t %s: sel=%0d state=%0d load=%0d", $time, tag, sel, state, load);
        check({tag, ".sel"},   int'(sel),   exp_sel);
        check({tag, ".state"}, int'(state), exp_state);
        check({tag, ".load"},  int'(load),  exp_load);
    endtask

    // Four ticks, ten clocks apart; leaves the DUT in IDLE.
    task automatic boot_seq(input string tag);
        for (int i = 1; i <= 4; i++) begin
            step(9);
            check({tag, ".boot_pre"}, int'(state), 0);
            pulse_tick();
            check({tag, ".boot_shift"}, shift_seen, 0);
        end
        outs({tag, ".boot_done"}, 1, 1, 0);
    endtask

    task automatic press_start(input string tag);
        start_n = 1'b0;
        step(1);
        outs({tag, ".load"}, 2, 2, 1);
        step(1);
        outs({tag, ".play"}, 3, 3, 0);
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; start_n = 1'b1; crash = 1'b0;
        step(2);
        outs("reset", 0, 0, 0);
        check("reset.shift", int'(shift), 0);
        rst = 1'b0;

        boot_seq("boot1");

        // Start held 20 clocks gives a single LOAD; a second press in PLAY is ignored.
        press_start("start1");
        step(18);
        outs("start1.hold", 3, 3, 0);
        start_n = 1'b1; step(2);
        start_n = 1'b0; step(2);
        outs("start1.repress", 3, 3, 0);
        start_n = 1'b1; step(1);

        // Three shifting ticks, then crash coincident with the fourth.
        for (int i = 0; i < 3; i++) begin
            step(3);
            pulse_tick();
            check("play.shift", shift_seen, 1);
        end
        step(3);
        crash = 1'b1; tick = 1'b1;
        #1 check("crash.shift", int'(shift), 0);
        @(negedge clk);
        crash = 1'b0; tick = 1'b0;
        outs("crash.entry", 0, 4, 0);

        // Start pressed during CRASH and held must not start a game on return to IDLE.
        start_n = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step(2);
            crash = 1'b1;
            pulse_tick();
            crash = 1'b0;
            if (k < 8) outs("crash.blink", (k % 2 == 1) ? 3 : 0, 4, 0);
            else       outs("crash.done", 1, 1, 0);
        end
        step(4);
        outs("crash.noqueue", 1, 1, 0);
        start_n = 1'b1; step(1);

        // Start held low through reset and boot is not a start event.
        start_n = 1'b0;
        rst = 1'b1; step(1); rst = 1'b0;
        boot_seq("held");
        step(5);
        outs("held.idle", 1, 1, 0);
        start_n = 1'b1; step(1);
        press_start("held.press");
        start_n = 1'b1;

        // Asynchronous reset mid-PLAY, with a tick up.
        step(2);
        tick = 1'b1;
        #2 rst = 1'b1;
        #1;
        outs("arst.play", 0, 0, 0);
        check("arst.play.shift", int'(shift), 0);
        @(negedge clk);
        tick = 1'b0; rst = 1'b0;
        boot_seq("boot2");

        // Asynchronous reset mid-CRASH.
        press_start("start2");
        start_n = 1'b1;
        step(1);
        crash = 1'b1; step(1); crash = 1'b0;
        outs("crash2.entry", 0, 4, 0);
        pulse_tick();
        outs("crash2.blink", 3, 4, 0);
        #2 rst = 1'b1;
        #1;
        outs("arst.crash", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        boot_seq("boot3");

        // Illegal state code recovers to BOOT on the next clock.
        force dut.state_reg = 3'd6;
        #1 release dut.state_reg;
        @(negedge clk);
        outs("illegal", 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
